// File: rtl/keypad_if.sv
// keypad_if: keypad pins and game-side outputs of the keypad encoder.
interface keypad_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] keypad_value;
  logic       check_answer;
  logic       key_held;
  modport master (input row, output col, keypad_value, check_answer, key_held);
  modport slave  (output row, input col, keypad_value, check_answer, key_held);
endinterface

// File: rtl/keypad_encoder.sv
// keypad_encoder: 4x4 keypad scanner, debouncer and digit/submit encoder.
// Optional KEYPAD_CLEAR_ON_SUBMIT_EN clears the digit the cycle after a submit strobe.
module keypad_encoder #(
  parameter int COL_CYCLES     = 12000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic      clk_12MHz,
  input logic      reset,
  keypad_if.master kp
);
  localparam int DW = $clog2(COL_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [1:0] IDLE = 2'd0, PRESS_DB = 2'd1, HELD = 2'd2, REL_DB = 2'd3;
  logic [3:0]    row_s1_q, row_s2_q, pr;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    ci_q, ci_d, hits_q, hits_d, state_q, state_d, frow;
  logic [3:0]    code_q, code_d, cand_q, cand_d, kv_q, kv_d, code;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]    tot;
  logic          ca_q, ca_d, last, round_end, valid, fire;
  always_comb begin
    pr        = ~row_s2_q;
    last      = dwell_q == DW'(COL_CYCLES - 1);
    round_end = last && ci_q == 2'd3;
    tot       = {1'b0, hits_q} + 3'(pr[0]) + 3'(pr[1]) + 3'(pr[2]) + 3'(pr[3]);
    frow      = pr[0] ? 2'd0 : pr[1] ? 2'd1 : pr[2] ? 2'd2 : 2'd3;
    code      = hits_q != 2'd0 ? code_q : {frow, ci_q};
    valid     = tot == 3'd1;
    dwell_d   = last ? '0 : dwell_q + DW'(1);
    ci_d      = last ? ci_q + 2'd1 : ci_q;
    hits_d    = !last ? hits_q : round_end ? 2'd0 : tot > 3'd2 ? 2'd2 : tot[1:0];
    code_d    = !last ? code_q : round_end ? 4'd0 : code;
    cnt_inc   = cnt_q + CW'(1);
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    fire      = 1'b0;
    if (round_end)
      case (state_q)
        IDLE: if (valid) begin
          cand_d  = code;
          cnt_d   = CW'(1);
          state_d = DEBOUNCE_SCANS == 1 ? HELD : PRESS_DB;
          fire    = DEBOUNCE_SCANS == 1;
        end
        PRESS_DB: if (valid && code == cand_q) begin
          cnt_d   = cnt_inc;
          state_d = cnt_inc == CW'(DEBOUNCE_SCANS) ? HELD : PRESS_DB;
          fire    = cnt_inc == CW'(DEBOUNCE_SCANS);
        end else state_d = IDLE;
        HELD: if (!valid) begin
          cnt_d   = CW'(1);
          state_d = DEBOUNCE_SCANS == 1 ? IDLE : REL_DB;
        end
        default: if (!valid) begin
          cnt_d   = cnt_inc;
          state_d = cnt_inc == CW'(DEBOUNCE_SCANS) ? IDLE : REL_DB;
        end else state_d = HELD;
      endcase
    ca_d = !(fire && code == 4'd14);
    kv_d = kv_q;
    // digits 1-9 sit in rows 0-2, cols 0-2: value = 3*row + col + 1
    if (fire && code[3:2] != 2'd3 && code[1:0] != 2'd3)
      kv_d = {code[3:2], 2'b00} - {2'b00, code[3:2]} + {2'b00, code[1:0]} + 4'd1;
    else if (fire && (code == 4'd12 || code == 4'd13))
      kv_d = 4'd0;
`ifdef KEYPAD_CLEAR_ON_SUBMIT_EN
    if (!ca_q) kv_d = 4'd0;
`else
`endif
  end
  always_ff @(posedge clk_12MHz) begin
    if (!reset) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      dwell_q  <= '0;
      ci_q     <= 2'd0;
      hits_q   <= 2'd0;
      code_q   <= 4'd0;
      state_q  <= IDLE;
      cand_q   <= 4'd0;
      cnt_q    <= '0;
      kv_q     <= 4'd0;
      ca_q     <= 1'b1;
    end else begin
      row_s1_q <= kp.row;
      row_s2_q <= row_s1_q;
      dwell_q  <= dwell_d;
      ci_q     <= ci_d;
      hits_q   <= hits_d;
      code_q   <= code_d;
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      kv_q     <= kv_d;
      ca_q     <= ca_d;
    end
  end
  assign kp.col          = ~(4'b0001 << ci_q);
  assign kp.keypad_value = kv_q;
  assign kp.check_answer = ca_q;
  assign kp.key_held     = state_q == HELD || state_q == REL_DB;
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: directed keypad scenarios with COL_CYCLES=4, DEBOUNCE_SCANS=2 (16-cycle rounds).
module tb_keypad_encoder;
  logic        clk_12MHz = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] keys = 16'h0;
  logic [3:0]  kv_prev = 4'h0;
  logic [3:0]  exp_kv;
  int          vecs = 0, errs = 0, ca_lows = 0, kv_chg = 0, base;
  keypad_if kp();
  keypad_encoder #(.COL_CYCLES(4), .DEBOUNCE_SCANS(2)) dut (
    .clk_12MHz(clk_12MHz),
    .reset(reset),
    .kp(kp)
  );
  always #5 clk_12MHz = ~clk_12MHz;
  // key matrix model: a pressed key pulls its row low while its column is driven
  always_comb begin
    kp.row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.col[c]) kp.row[r] = 1'b0;
  end
  always @(negedge clk_12MHz) begin
    ca_lows <= ca_lows + (kp.check_answer ? 0 : 1);
    kv_chg  <= kv_chg + (kp.keypad_value != kv_prev ? 1 : 0);
    kv_prev <= kp.keypad_value;
  end
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_12MHz);
      #1;
    end
  endtask
  initial begin
    repeat (3) @(posedge clk_12MHz);
    #1;
    reset = 1'b1;
    chk("rst_kv", 8'(kp.keypad_value), 8'd0);
    chk("rst_ca", 8'(kp.check_answer), 8'd1);
    chk("rst_held", 8'(kp.key_held), 8'd0);
    for (int k = 0; k < 16; k++) begin
      chk("col_seq", 8'(kp.col), 8'(~(4'b0001 << (k / 4)) & 4'hF));
      step(1);
    end
    base = kv_chg;
    keys = 16'h1 << 8;
    step(31);
    chk("seven_early", 8'(kp.keypad_value), 8'd0);
    step(1);
    chk("seven_kv", 8'(kp.keypad_value), 8'd7);
    chk("seven_held", 8'(kp.key_held), 8'd1);
    chk("seven_ca", 8'(kp.check_answer), 8'd1);
    step(16);
    chk("seven_once", 8'(kv_chg - base), 8'd1);
    keys = 16'h0;
    step(31);
    chk("rel_held", 8'(kp.key_held), 8'd1);
    step(1);
    chk("rel_idle", 8'(kp.key_held), 8'd0);
    base = ca_lows;
    keys = 16'h1 << 14;
    step(31);
    chk("hash_pre", 8'(kp.check_answer), 8'd1);
    step(1);
    chk("hash_ca", 8'(kp.check_answer), 8'd0);
    chk("hash_kv", 8'(kp.keypad_value), 8'd7);
    step(1);
`ifdef KEYPAD_CLEAR_ON_SUBMIT_EN
    exp_kv = 4'd0;
`else
    exp_kv = 4'd7;
`endif
    chk("hash_ca_end", 8'(kp.check_answer), 8'd1);
    chk("hash_kv_after", 8'(kp.keypad_value), 8'(exp_kv));
    step(15);
    keys = 16'h0;
    step(32);
    chk("hash_one_pulse", 8'(ca_lows - base), 8'd1);
    chk("hash_rel", 8'(kp.key_held), 8'd0);
    for (int i = 0; i < 4; i++) begin
      keys = (i % 2 == 0) ? 16'h1 << 5 : 16'h0;
      step(16);
    end
    chk("bounce_kv", 8'(kp.keypad_value), 8'(exp_kv));
    keys = 16'h1 << 5;
    step(32);
    chk("five_kv", 8'(kp.keypad_value), 8'd5);
    keys = 16'h0;
    step(32);
    keys = (16'h1 << 2) | (16'h1 << 10);
    step(48);
    chk("multi_kv", 8'(kp.keypad_value), 8'd5);
    chk("multi_held", 8'(kp.key_held), 8'd0);
    keys = 16'h1 << 9;
    step(32);
    chk("eight_kv", 8'(kp.keypad_value), 8'd8);
    keys = 16'h0;
    step(32);
    keys = 16'h1 << 3;
    step(32);
    chk("a_kv", 8'(kp.keypad_value), 8'd8);
    chk("a_held", 8'(kp.key_held), 8'd1);
    keys = 16'h0;
    step(32);
    keys = 16'h1 << 12;
    step(32);
    chk("star_kv", 8'(kp.keypad_value), 8'd0);
    keys = 16'h0;
    step(32);
    chk("star_rel", 8'(kp.key_held), 8'd0);
    keys = 16'h1 << 8;
    step(32);
    chk("seven2_kv", 8'(kp.keypad_value), 8'd7);
    keys = 16'h0;
    step(32);
    base = ca_lows;
    keys = 16'h1 << 14;
    step(20);
    reset = 1'b0;
    step(1);
    chk("abort_col", 8'(kp.col), 8'he);
    chk("abort_kv", 8'(kp.keypad_value), 8'd0);
    chk("abort_ca", 8'(kp.check_answer), 8'd1);
    chk("abort_held", 8'(kp.key_held), 8'd0);
    keys = 16'h0;
    step(2);
    reset = 1'b1;
    step(32);
    chk("abort_no_pulse", 8'(ca_lows - base), 8'd0);
    chk("abort_kv_end", 8'(kp.keypad_value), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
